adder_checker: RTL and testbench

ADDER_CHECKER -- requirements
Module: adder_checker

---
 rtl/adder_checker.sv | 154 +++++++++++++++
 tb/tb_adder_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adder_checker.sv
// Online checker for a 4-bit adder: registers each sampled vector, compares it
// against a + b + cin on the following edge, and keeps pass/fail statistics.
module adder_checker #(
  parameter int NUM_VECTORS  = 256,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_clear,
  input  logic        i_sample,
  input  logic [3:0]  i_a,
  input  logic [3:0]  i_b,
  input  logic        i_cin,
  input  logic [3:0]  i_sum,
  input  logic        i_cout,
  output logic [7:0]  o_pass_cnt,
  output logic [7:0]  o_fail_cnt,
  output logic        o_err_flag,
  output logic [13:0] o_first_fail,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [8:0] LP_NUM_VECTORS = 9'(NUM_VECTORS);

  function automatic logic [4:0] f_expected(input logic [3:0] a, input logic [3:0] b,
                                            input logic cin);
    return {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic        r_s1_valid;
  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic        r_cin;
  logic [3:0]  r_sum;
  logic        r_cout;
  logic [8:0]  r_checked;
  logic [7:0]  r_pass_cnt;
  logic [7:0]  r_fail_cnt;
  logic        r_err_flag;
  logic [13:0] r_first_fail;
  logic        r_busy;
  logic        r_done;

  logic        w_clr;
  logic        w_count_en;
  logic        w_match;
  logic [8:0]  w_checked_next;

  assign w_clr          = i_rst | i_clear;
  // A captured vector is only scored while still running; this drops the one behind a stop.
  assign w_count_en     = r_s1_valid & (r_state == S_RUN);
  assign w_match        = ({r_cout, r_sum} == f_expected(r_a, r_b, r_cin));
  assign w_checked_next = r_checked + 9'd1;

  // State register
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a stopping mismatch wins over reaching the vector count
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_count_en && !w_match && (STOP_ON_FAIL == 1'b1)) begin
          w_next_state = S_FAIL;
        end else if (w_count_en && (w_checked_next == LP_NUM_VECTORS)) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE:  w_next_state = S_DONE;
      S_FAIL:  w_next_state = S_FAIL;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Capture stage, scoring stage and registered status outputs
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_s1_valid   <= 1'b0;
      r_a          <= 4'h0;
      r_b          <= 4'h0;
      r_cin        <= 1'b0;
      r_sum        <= 4'h0;
      r_cout       <= 1'b0;
      r_checked    <= 9'd0;
      r_pass_cnt   <= 8'd0;
      r_fail_cnt   <= 8'd0;
      r_err_flag   <= 1'b0;
      r_first_fail <= 14'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_s1_valid <= i_sample & (r_state == S_RUN);
      if (i_sample && (r_state == S_RUN)) begin
        r_a    <= i_a;
        r_b    <= i_b;
        r_cin  <= i_cin;
        r_sum  <= i_sum;
        r_cout <= i_cout;
      end
      if (w_count_en) begin
        r_checked <= w_checked_next;
        if (w_match) begin
          if (r_pass_cnt != 8'hFF) begin
            r_pass_cnt <= r_pass_cnt + 8'd1;
          end
        end else begin
          if (r_fail_cnt != 8'hFF) begin
            r_fail_cnt <= r_fail_cnt + 8'd1;
          end
          r_err_flag <= 1'b1;
          if (!r_err_flag) begin
            r_first_fail <= {r_a, r_b, r_cin, r_sum, r_cout};
          end
        end
      end
      r_busy <= (w_next_state == S_RUN);
      r_done <= (w_next_state == S_DONE) || (w_next_state == S_FAIL);
    end
  end

  assign o_pass_cnt   = r_pass_cnt;
  assign o_fail_cnt   = r_fail_cnt;
  assign o_err_flag   = r_err_flag;
  assign o_first_fail = r_first_fail;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_adder_checker.sv
// Directed bench for adder_checker: one instance stops on first mismatch with the
// default count, the other logs mismatches and completes after 16 vectors.
module tb_adder_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        sample = 1'b0;
  logic [3:0]  a = 4'h0;
  logic [3:0]  b = 4'h0;
  logic        cin = 1'b0;
  logic [3:0]  sum = 4'h0;
  logic        cout = 1'b0;

  logic [7:0]  s_pass, s_fail, c_pass, c_fail;
  logic        s_err, s_busy, s_done, c_err, c_busy, c_done;
  logic [13:0] s_ff, c_ff;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  adder_checker u_stop (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear), .i_sample(sample),
    .i_a(a), .i_b(b), .i_cin(cin), .i_sum(sum), .i_cout(cout),
    .o_pass_cnt(s_pass), .o_fail_cnt(s_fail), .o_err_flag(s_err),
    .o_first_fail(s_ff), .o_busy(s_busy), .o_done(s_done)
  );

  adder_checker #(.NUM_VECTORS(16), .STOP_ON_FAIL(1'b0)) u_cont (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear), .i_sample(sample),
    .i_a(a), .i_b(b), .i_cin(cin), .i_sum(sum), .i_cout(cout),
    .o_pass_cnt(c_pass), .o_fail_cnt(c_fail), .o_err_flag(c_err),
    .o_first_fail(c_ff), .o_busy(c_busy), .o_done(c_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; sample = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drive one sampled vector for one cycle; bad=1 corrupts the low sum bit.
  task automatic drive_vec(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                           input logic bad);
    logic [4:0] t;
    t = {1'b0, va} + {1'b0, vb} + {4'b0000, vc};
    a = va; b = vb; cin = vc; sum = t[3:0] ^ {3'b000, bad}; cout = t[4];
    sample = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({s_pass, s_fail} !== 16'h0000) $display("FAIL reset_cnt: got %h want 0000", {s_pass, s_fail}); else n_pass++;
    n_checks++; if ({s_err, s_busy, s_done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {s_err, s_busy, s_done}); else n_pass++;
    n_checks++; if (s_ff !== 14'd0) $display("FAIL reset_first_fail: got %h want 0000", s_ff); else n_pass++;
    // samples before start are ignored
    drive_vec(4'h1, 4'h2, 1'b0, 1'b1);
    drive_vec(4'h3, 4'h3, 1'b0, 1'b0);
    sample = 1'b0;
    step();
    n_checks++; if ({s_pass, s_fail, s_busy} !== 17'd0) $display("FAIL idle_sample: got %h want 0", {s_pass, s_fail, s_busy}); else n_pass++;
  endtask

  task automatic test_full_run();
    logic [7:0] i8;
    do_reset();
    do_start();
    n_checks++; if (s_busy !== 1'b1) $display("FAIL run_busy: got %b want 1", s_busy); else n_pass++;
    for (int i = 0; i < 256; i++) begin
      i8 = 8'(i);
      drive_vec(i8[3:0], i8[7:4], 1'b0, 1'b0);
    end
    sample = 1'b0;
    n_checks++; if (s_done !== 1'b0) $display("FAIL full_done_early: got %b want 0", s_done); else n_pass++;
    step();
    n_checks++; if (s_pass !== 8'd255) $display("FAIL full_pass_sat: got %0d want 255", s_pass); else n_pass++;
    n_checks++; if (s_fail !== 8'd0) $display("FAIL full_fail: got %0d want 0", s_fail); else n_pass++;
    n_checks++; if ({s_done, s_busy, s_err} !== 3'b100) $display("FAIL full_flags: got %b want 100", {s_done, s_busy, s_err}); else n_pass++;
    // samples and start after DONE change nothing
    drive_vec(4'h3, 4'h4, 1'b1, 1'b1);
    drive_vec(4'h5, 4'h6, 1'b0, 1'b1);
    sample = 1'b0;
    do_start();
    step();
    n_checks++; if ({s_pass, s_fail} !== {8'd255, 8'd0}) $display("FAIL done_hold_cnt: got %h want ff00", {s_pass, s_fail}); else n_pass++;
    n_checks++; if ({s_done, s_busy, s_err} !== 3'b100) $display("FAIL done_hold_flags: got %b want 100", {s_done, s_busy, s_err}); else n_pass++;
  endtask

  task automatic test_stop_on_fail();
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) drive_vec(4'h1, 4'h1, 1'b0, 1'b0);
    a = 4'h3; b = 4'h4; cin = 1'b1; sum = 4'h7; cout = 1'b0; sample = 1'b1;
    step();
    for (int i = 0; i < 3; i++) drive_vec(4'h2, 4'h2, 1'b0, 1'b0);
    sample = 1'b0;
    step();
    n_checks++; if ({s_pass, s_fail} !== {8'd4, 8'd1}) $display("FAIL stop_cnt: got %h want 0401", {s_pass, s_fail}); else n_pass++;
    n_checks++; if (s_ff !== {4'h3, 4'h4, 1'b1, 4'h7, 1'b0}) $display("FAIL stop_first_fail: got %h want 0d2e", s_ff); else n_pass++;
    n_checks++; if ({s_err, s_done, s_busy} !== 3'b110) $display("FAIL stop_flags: got %b want 110", {s_err, s_done, s_busy}); else n_pass++;
  endtask

  task automatic test_continue();
    logic [4:0] k5;
    do_reset();
    do_start();
    for (int k = 1; k <= 16; k++) begin
      k5 = 5'(k);
      drive_vec(k5[3:0], 4'h2, k5[0], (k == 2 || k == 9) ? 1'b1 : 1'b0);
    end
    sample = 1'b0;
    step();
    n_checks++; if ({c_pass, c_fail} !== {8'd14, 8'd2}) $display("FAIL cont_cnt: got %h want 0e02", {c_pass, c_fail}); else n_pass++;
    n_checks++; if (c_ff !== {4'h2, 4'h2, 1'b0, 4'h5, 1'b0}) $display("FAIL cont_first_fail: got %h want %h", c_ff, {4'h2, 4'h2, 1'b0, 4'h5, 1'b0}); else n_pass++;
    n_checks++; if ({c_err, c_done, c_busy} !== 3'b110) $display("FAIL cont_flags: got %b want 110", {c_err, c_done, c_busy}); else n_pass++;
  endtask

  task automatic test_boundary();
    do_reset();
    do_start();
    a = 4'hF; b = 4'hF; cin = 1'b1; sum = 4'hF; cout = 1'b1; sample = 1'b1;
    step();
    a = 4'hF; b = 4'hF; cin = 1'b1; sum = 4'hF; cout = 1'b0;
    step();
    sample = 1'b0;
    n_checks++; if ({s_pass, s_fail, s_err} !== {8'd1, 8'd0, 1'b0}) $display("FAIL bound_pass: got %h want %h", {s_pass, s_fail, s_err}, {8'd1, 8'd0, 1'b0}); else n_pass++;
    step();
    n_checks++; if ({c_pass, c_fail, c_busy} !== {8'd1, 8'd1, 1'b1}) $display("FAIL bound_mismatch: got %h want %h", {c_pass, c_fail, c_busy}, {8'd1, 8'd1, 1'b1}); else n_pass++;
  endtask

  task automatic test_clear_mid_run();
    do_reset();
    do_start();
    drive_vec(4'h1, 4'h1, 1'b0, 1'b1);
    drive_vec(4'h2, 4'h3, 1'b1, 1'b1);
    clear = 1'b1;
    drive_vec(4'h4, 4'h4, 1'b0, 1'b1);
    clear = 1'b0;
    sample = 1'b0;
    n_checks++; if ({s_pass, s_fail, s_err, s_busy, s_done, s_ff} !== 33'd0) $display("FAIL clear_outputs: got %h want 0", {s_pass, s_fail, s_err, s_busy, s_done, s_ff}); else n_pass++;
    step();
    n_checks++; if ({c_pass, c_fail, c_err, c_busy, c_done, c_ff} !== 33'd0) $display("FAIL clear_no_update: got %h want 0", {c_pass, c_fail, c_err, c_busy, c_done, c_ff}); else n_pass++;
  endtask

  task automatic test_start_clear();
    do_reset();
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    drive_vec(4'h1, 4'h1, 1'b0, 1'b1);
    sample = 1'b0;
    step();
    n_checks++; if ({s_busy, s_done, s_fail} !== 10'd0) $display("FAIL start_clear: got %h want 0", {s_busy, s_done, s_fail}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_stop_on_fail();
    test_continue();
    test_boundary();
    test_clear_mid_run();
    test_start_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
